display_share_arbiter: RTL and testbench



---
 rtl/display_share_arbiter_pkg.sv | 19 +
 rtl/display_share_arbiter_rr_pick.sv | 32 +++
 rtl/display_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_display_share_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_share_arbiter_pkg.sv
// Shared types and helpers for the display share arbiter.
// State encoding plus small width helpers.
package display_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req after ptr.
// In: req, ptr. Out: one-hot win, its index win_idx, found flag.
module rr_pick #(
  parameter int n_req = 4,
  parameter int ptr_w = 2
) (
  input  logic [n_req-1:0] req,
  input  logic [ptr_w-1:0] ptr,
  output logic [n_req-1:0] win,
  output logic [ptr_w-1:0] win_idx,
  output logic             found
);

  logic [ptr_w-1:0] idx;

  // Scan ptr+1 .. ptr+n_req; the last step wraps onto ptr itself.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= n_req; k++) begin
      idx = ptr_w'((int'(ptr) + k) % n_req);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin time-sharing of one seven-segment display with dwell.
// Ports: clk, rst (async low), req, number_in, dots_in, hold -> grant,
// number, dots. Macro DISPLAY_SHARE_ARBITER_BLANK_EN adds a blank gap.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter int clk_mhz      = 50,
  parameter int n_req        = 4,
  parameter int w_digit      = 8,
  parameter int dwell_cycles = clk_mhz * 500000,
  parameter int blank_cycles = clk_mhz * 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_req-1:0]           req,
  input  logic [n_req*w_digit*4-1:0] number_in,
  input  logic [n_req*w_digit-1:0]   dots_in,
  input  logic                       hold,
  output logic [n_req-1:0]           grant,
  output logic [w_digit*4-1:0]       number,
  output logic [w_digit-1:0]         dots
);

  localparam int w_number = w_digit * 4;
  localparam int ptr_w    = clog2_min1(n_req);
  localparam int cnt_w    =
    $clog2(max_int(dwell_cycles, blank_cycles) + 1);
  localparam logic [cnt_w-1:0] dwell_last =
    cnt_w'(dwell_cycles - 1);
`ifdef DISPLAY_SHARE_ARBITER_BLANK_EN
  localparam logic [cnt_w-1:0] blank_last =
    cnt_w'(blank_cycles - 1);
`endif

  state_e               state_q, state_d;
  logic [n_req-1:0]     grant_q, grant_d;
  logic [ptr_w-1:0]     ptr_q, ptr_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [w_number-1:0]  number_q, number_d;
  logic [w_digit-1:0]   dots_q, dots_d;

  logic [n_req-1:0]     pick_req;
  logic [n_req-1:0]     win;
  logic [ptr_w-1:0]     win_idx;
  logic                 found;
  logic                 owner_req;
  logic                 expired;
  logic                 take;

  // While showing, the owner is masked so "found" means another source.
  assign pick_req  = (state_q == SHOW) ? (req & ~grant_q) : req;
  assign owner_req = |(req & grant_q);
  assign expired   = (cnt_q == dwell_last);

  rr_pick #(
    .n_req (n_req),
    .ptr_w (ptr_w)
  ) u_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      SHOW: begin
        // Drop wins over expiry; both end the current grant.
        if (!owner_req || (expired && !hold && found)) begin
`ifdef DISPLAY_SHARE_ARBITER_BLANK_EN
          state_d = BLANK;
          grant_d = '0;
          cnt_d   = '0;
`else
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`endif
        end else if (!expired) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
`ifdef DISPLAY_SHARE_ARBITER_BLANK_EN
      BLANK: begin
        if (cnt_q == blank_last) begin
          if (found) take = 1'b1;
          else       state_d = IDLE;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      state_d = SHOW;
      grant_d = win;
      ptr_d   = win_idx;
      cnt_d   = '0;
    end
  end

  // Data follows the grant taking effect on the same edge.
  always_comb begin
    number_d = '0;
    dots_d   = '0;
    for (int i = 0; i < n_req; i++) begin
      if (grant_d[i]) begin
        number_d |= number_in[i*w_number +: w_number];
        dots_d   |= dots_in[i*w_digit +: w_digit];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= ptr_w'(n_req - 1);
      cnt_q    <= '0;
      number_q <= '0;
      dots_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      dots_q   <= dots_d;
    end
  end

  assign grant  = grant_q;
  assign number = number_q;
  assign dots   = dots_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Randomised bench for display_share_arbiter with a reference model.
// Honours DISPLAY_SHARE_ARBITER_BLANK_EN for the blank-gap behaviour.
module tb_display_share_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          hold;
  logic [N*32-1:0] number_in;
  logic [N*8-1:0]  dots_in;
  logic [N-1:0]  grant;
  logic [31:0]   number;
  logic [7:0]    dots;

  logic [31:0]   nums [N];
  logic [7:0]    dts  [N];

  int n_checks = 0;
  int n_errors = 0;

  int m_owner, m_age, m_ptr, m_blank;
  logic [N-1:0] e_grant;
  logic [31:0]  e_num;
  logic [7:0]   e_dots;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      number_in[i*32 +: 32] = nums[i];
      dots_in[i*8 +: 8]     = dts[i];
    end
  end

  display_share_arbiter #(
    .n_req        (N),
    .w_digit      (8),
    .dwell_cycles (DWELL),
    .blank_cycles (BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .number_in (number_in),
    .dots_in   (dots_in),
    .hold      (hold),
    .grant     (grant),
    .number    (number),
    .dots      (dots)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // First requester strictly after 'from', wrapping; -1 if none.
  function automatic int next_after(input int from,
                                    input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner = w;
    if (w >= 0) begin
      m_ptr = w;
      m_age = 0;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_ptr   = N - 1;
    m_blank = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] other;
    if (m_blank > 0) begin
      if (m_blank == 1) begin
        m_blank = 0;
        grant_to(next_after(m_ptr, req));
      end else begin
        m_blank--;
      end
    end else if (m_owner < 0) begin
      grant_to(next_after(m_ptr, req));
    end else begin
      other = req;
      other[m_owner] = 1'b0;
      if (!req[m_owner] ||
          (m_age >= DWELL - 1 && !hold && other != '0)) begin
`ifdef DISPLAY_SHARE_ARBITER_BLANK_EN
        m_owner = -1;
        m_blank = BLANK;
`else
        grant_to(next_after(m_owner, other));
`endif
      end else begin
        m_age++;
      end
    end
    e_grant = '0;
    e_num   = '0;
    e_dots  = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_num  = nums[m_owner];
      e_dots = dts[m_owner];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("grant",  32'(grant),  32'(e_grant));
    check("number", number,      e_num);
    check("dots",   32'(dots),   32'(e_dots));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_grant",  32'(grant), 32'h0);
    check("rst_number", number,     32'h0);
    check("rst_dots",   32'(dots),  32'h0);
    model_reset();
    req  = '0;
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    req  = '0;
    hold = 1'b0;
    for (int i = 0; i < N; i++) begin
      nums[i] = 32'h1111_0000 * (i + 1);
      dts[i]  = 8'(i + 1);
    end
    model_reset();

    // Reset and first request
    do_reset();
    nums[1] = 32'h0000_1234;
    req = 4'b0110;
    cycle();
    check("first_grant",  32'(grant), 32'h2);
    check("first_number", number,     32'h0000_1234);

    // Rotation with all sources requesting
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < DWELL; c++) begin
        cycle();
`ifndef DISPLAY_SHARE_ARBITER_BLANK_EN
        check("rotation", 32'(grant), 32'(1 << (s % N)));
`endif
      end

    // Drop of the granted source
    do_reset();
    req = 4'b0100;
    cycle();
    check("drop_own", 32'(grant), 32'h4);
    req = 4'b1100;
    cycle();
    cycle();
    req = 4'b1000;
    cycle();
`ifndef DISPLAY_SHARE_ARBITER_BLANK_EN
    check("drop_next", 32'(grant), 32'h8);
    req = '0;
    cycle();
    check("drop_idle", 32'(grant), 32'h0);
    check("drop_num",  number,     32'h0);
`endif
    req = '0;
    repeat (4) cycle();

    // Hold and lone requester
    do_reset();
    hold = 1'b1;
    req  = 4'b0011;
    repeat (30) begin
      cycle();
      check("hold", 32'(grant), 32'h1);
    end
    hold = 1'b0;
    req  = 4'b0001;
    repeat (20) begin
      cycle();
      check("lone", 32'(grant), 32'h1);
    end
    req = 4'b1001;
    cycle();
`ifndef DISPLAY_SHARE_ARBITER_BLANK_EN
    check("late_req", 32'(grant), 32'h8);
`endif
    repeat (4) cycle();

    // Live tracking, then asynchronous reset mid-show
    req = 4'b1000;
    repeat (3) cycle();
    nums[3] = $urandom;
    dts[3]  = 8'($urandom);
    cycle();
    check("live_num", number, nums[3]);
    check("live_dots", 32'(dots), 32'(dts[3]));
    do_reset();

`ifdef DISPLAY_SHARE_ARBITER_BLANK_EN
    // Blank gap on a switch
    req = 4'b0011;
    repeat (DWELL) cycle();
    for (int b = 0; b < BLANK; b++) begin
      cycle();
      check("blank_grant", 32'(grant), 32'h0);
      check("blank_num",   number,     32'h0);
    end
    cycle();
    check("after_blank", 32'(grant), 32'h2);
    do_reset();
`endif

    // Randomised traffic
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        nums[$urandom_range(0, N-1)] = $urandom;
        dts[$urandom_range(0, N-1)]  = 8'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
